// File: rtl/easy_fifo_axis_arbiter.sv
// easy_fifo_axis_arbiter: round-robin N:1 AXIS arbiter tagging beats with source index; packet lock via EASY_FIFO_ARB_PKT_LOCK_EN
module easy_fifo_axis_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DWIDTH = 32,
  parameter int SRC_WIDTH = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DWIDTH-1:0] s_axis_tdata,
  input  logic [NUM_IN-1:0]        s_axis_tvalid,
  input  logic [NUM_IN-1:0]        s_axis_tlast,
  output logic [NUM_IN-1:0]        s_axis_tready,
  output logic [DWIDTH-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [SRC_WIDTH-1:0]     m_axis_tdest,
  input  logic                     m_axis_tready,
  output logic [SRC_WIDTH-1:0]     grant,
  output logic                     busy
);
  logic [SRC_WIDTH-1:0] last, win, src, idx;
  logic [DWIDTH-1:0] data;
  logic out_free, any, acc;
  // ready is held low while reset is asserted
  assign out_free = rst_n && (!m_axis_tvalid || m_axis_tready);
  assign any = |s_axis_tvalid;
  assign acc = |(s_axis_tready & s_axis_tvalid);
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = SRC_WIDTH'((int'(last) + k) % NUM_IN);
      if (s_axis_tvalid[idx]) win = idx;
    end
  end
  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (src == SRC_WIDTH'(i)) data = s_axis_tdata[i*DWIDTH +: DWIDTH];
  end
`ifdef EASY_FIFO_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // while locked, last is the owner of the packet
  always_comb begin
    nxt = state;
    s_axis_tready = '0;
    src = win;
    if (state == LOCKED) begin
      src = last;
      s_axis_tready[last] = out_free;
      if (out_free && s_axis_tvalid[last] && s_axis_tlast[last]) nxt = IDLE;
    end else if (out_free && any) begin
      s_axis_tready[win] = 1'b1;
      if (!s_axis_tlast[win]) nxt = LOCKED;
    end
  end
  assign busy = state == LOCKED;
`else
  always_comb begin
    s_axis_tready = '0;
    s_axis_tready[win] = out_free && any;
  end
  assign src = win;
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= SRC_WIDTH'(NUM_IN - 1);
      grant <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tdest <= '0;
    end else if (acc) begin
      last <= src;
      grant <= src;
      m_axis_tvalid <= 1'b1;
      m_axis_tdata <= data;
      m_axis_tlast <= s_axis_tlast[src];
      m_axis_tdest <= src;
    end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
endmodule
